// File: rtl/mbox_pkg.sv
// mbox_pkg: shared state/requester types and word-count decode for the MBOX core-memory arbiter
package mbox_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_ACK,
        S_WAIT_DATA,
        S_NXM,
        S_DONE
    } mbox_arb_state_t;

    typedef enum logic [1:0] {
        CHAN,
        WB,
        EBOX
    } mbox_req_t;

    // A requester word count of 0 means a full four-word transfer.
    function automatic logic [2:0] nwords_to_wc(input logic [1:0] nwords);
        return nwords == 2'd0 ? 3'd4 : {1'b0, nwords};
    endfunction

endpackage

// File: rtl/mbox_arb_prio.sv
// mbox_arb_prio: requester priority pick (channel > writeback > EBOX) with optional EBOX starvation promotion
//   Optional feature: MBOX_ARB_STARVE_EN enables the EBOX lost-arbitration counter.
//   clk_i, rst_i : clock and asynchronous active-high reset (used only by the starvation counter)
//   arb_i        : an arbitration is taken this cycle
//   *_req_i      : requests from channel, writeback and EBOX
//   win_o        : the winning requester
module mbox_arb_prio
    import mbox_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      arb_i,
    input  logic      chan_req_i,
    input  logic      wb_req_i,
    input  logic      ebox_req_i,
    output mbox_req_t win_o
);

`ifdef MBOX_ARB_STARVE_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

    logic [CW-1:0] lost_q, lost_d;

    assign win_o  = ebox_req_i && lost_q >= LIM ? EBOX : chan_req_i ? CHAN : wb_req_i ? WB : EBOX;
    // Once at the limit EBOX wins, so the counter can never step past it.
    assign lost_d = !arb_i ? lost_q : win_o == EBOX ? '0 : ebox_req_i ? lost_q + CW'(1) : lost_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) lost_q <= '0;
        else       lost_q <= lost_d;
    end
`else
    logic unused_ok;

    assign win_o     = chan_req_i ? CHAN : wb_req_i ? WB : EBOX;
    assign unused_ok = clk_i ^ rst_i ^ arb_i ^ (STARVE_LIMIT > 0);
`endif

endmodule

// File: rtl/mbox_core_arb.sv
// mbox_core_arb: MBOX core-memory port arbiter and cycle sequencer with NXM recovery
//   Optional feature: MBOX_ARB_STARVE_EN (EBOX starvation promotion, see mbox_arb_prio).
//   clk_mbx_h, mr_reset_h            : clock, asynchronous active-high reset
//   *_req_h, *_wr_h, *_nwords_h      : requester inputs (writeback is always a write)
//   grant_*_h                        : one-hot grant, held START through DONE
//   mem_start_h, mem_rd_rq_h, mem_wr_rq_h, mem_ackn_h, mem_data_val_h, mem_adr_par_err_h : memory port
//   core_busy_h, data_val_h, cyc_done_h, nxm_any_h : cycle status to requesters
//   nxm_err_chan_h, nxm_err_ebox_h, adr_par_err_h, err_clr_h : sticky error flags and their clear
module mbox_core_arb
    import mbox_pkg::*;
#(
    parameter int NXM_TIMEOUT  = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic       clk_mbx_h,
    input  logic       mr_reset_h,
    input  logic       chan_req_h,
    input  logic       wb_req_h,
    input  logic       ebox_req_h,
    input  logic       chan_wr_h,
    input  logic       ebox_wr_h,
    input  logic [1:0] chan_nwords_h,
    input  logic [1:0] wb_nwords_h,
    input  logic [1:0] ebox_nwords_h,
    output logic       grant_chan_h,
    output logic       grant_wb_h,
    output logic       grant_ebox_h,
    output logic       mem_start_h,
    output logic       mem_rd_rq_h,
    output logic       mem_wr_rq_h,
    input  logic       mem_ackn_h,
    input  logic       mem_data_val_h,
    input  logic       mem_adr_par_err_h,
    output logic       core_busy_h,
    output logic       data_val_h,
    output logic       cyc_done_h,
    output logic       nxm_any_h,
    output logic       nxm_err_chan_h,
    output logic       nxm_err_ebox_h,
    output logic       adr_par_err_h,
    input  logic       err_clr_h
);

    localparam int TW = $clog2(NXM_TIMEOUT + 1);
    localparam logic [TW:0] TMO = (TW + 1)'(NXM_TIMEOUT);

    mbox_arb_state_t state_q, state_d;
    mbox_req_t       req_q, req_d, win;
    logic            wr_q, wr_d;
    logic [2:0]      wc_q, wc_d, cnt_q, cnt_d;
    logic [TW-1:0]   tmr_q, tmr_d, tmr_sat;
    logic [TW:0]     tmr_nxt;
    logic            nxm_chan_q, nxm_chan_d, nxm_ebox_q, nxm_ebox_d, par_q, par_d;
    logic            any_req, ack_evt, dv_evt, syn_dv, last, tmo;

    assign any_req = chan_req_h | wb_req_h | ebox_req_h;

    mbox_arb_prio #(.STARVE_LIMIT(STARVE_LIMIT)) u_prio (
        .clk_i      (clk_mbx_h),
        .rst_i      (mr_reset_h),
        .arb_i      (state_q == S_IDLE && any_req),
        .chan_req_i (chan_req_h),
        .wb_req_i   (wb_req_h),
        .ebox_req_i (ebox_req_h),
        .win_o      (win)
    );

    assign ack_evt = (state_q == S_START || state_q == S_WAIT_ACK) && mem_ackn_h;
    assign dv_evt  = !wr_q && mem_data_val_h && (state_q == S_WAIT_DATA || ack_evt);
    // Synthesized words come from state alone, so they are free of input paths.
    assign syn_dv  = state_q == S_NXM && !wr_q && cnt_q < wc_q;
    assign last    = cnt_q + 3'd1 == wc_q;
    // The cycle holding START, ACKN or a data word counts as the first of the timeout window.
    assign tmr_nxt = (state_q == S_START || ack_evt || dv_evt ? '0 : {1'b0, tmr_q}) + (TW + 1)'(1);
    assign tmo     = tmr_nxt >= TMO;
    assign tmr_sat = tmo ? TMO[TW-1:0] : tmr_nxt[TW-1:0];

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        wr_d    = wr_q;
        wc_d    = wc_q;
        cnt_d   = dv_evt || syn_dv ? cnt_q + 3'd1 : cnt_q;
        tmr_d   = '0;
        case (state_q)
            S_IDLE: if (any_req) begin
                state_d = S_START;
                req_d   = win;
                wr_d    = win == CHAN ? chan_wr_h : win == WB ? 1'b1 : ebox_wr_h;
                wc_d    = nwords_to_wc(win == CHAN ? chan_nwords_h : win == WB ? wb_nwords_h : ebox_nwords_h);
                cnt_d   = '0;
            end
            S_START, S_WAIT_ACK: begin
                tmr_d   = tmr_sat;
                state_d = ack_evt ? (wr_q || (dv_evt && last) ? S_DONE : S_WAIT_DATA)
                                  : tmo ? S_NXM : S_WAIT_ACK;
            end
            S_WAIT_DATA: begin
                tmr_d   = tmr_sat;
                state_d = dv_evt ? (last ? S_DONE : S_WAIT_DATA) : tmo ? S_NXM : S_WAIT_DATA;
            end
            S_NXM:   state_d = syn_dv && !last ? S_NXM : S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // A new error always wins over a clear in the same cycle.
    assign nxm_chan_d = (state_q == S_NXM && req_q == CHAN) || (nxm_chan_q && !err_clr_h);
    assign nxm_ebox_d = (state_q == S_NXM && req_q != CHAN) || (nxm_ebox_q && !err_clr_h);
    assign par_d      = (ack_evt && mem_adr_par_err_h) || (par_q && !err_clr_h);

    always_ff @(posedge clk_mbx_h or posedge mr_reset_h) begin
        if (mr_reset_h) begin
            state_q    <= S_IDLE;
            req_q      <= CHAN;
            wr_q       <= 1'b0;
            wc_q       <= '0;
            cnt_q      <= '0;
            tmr_q      <= '0;
            nxm_chan_q <= 1'b0;
            nxm_ebox_q <= 1'b0;
            par_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            wr_q       <= wr_d;
            wc_q       <= wc_d;
            cnt_q      <= cnt_d;
            tmr_q      <= tmr_d;
            nxm_chan_q <= nxm_chan_d;
            nxm_ebox_q <= nxm_ebox_d;
            par_q      <= par_d;
        end
    end

    assign core_busy_h    = state_q != S_IDLE;
    assign grant_chan_h   = core_busy_h && req_q == CHAN;
    assign grant_wb_h     = core_busy_h && req_q == WB;
    assign grant_ebox_h   = core_busy_h && req_q == EBOX;
    assign mem_start_h    = state_q == S_START;
    assign mem_rd_rq_h    = core_busy_h && !wr_q;
    assign mem_wr_rq_h    = core_busy_h && wr_q;
    assign data_val_h     = dv_evt || syn_dv;
    assign cyc_done_h     = state_q == S_DONE;
    assign nxm_any_h      = state_q == S_NXM;
    assign nxm_err_chan_h = nxm_chan_q;
    assign nxm_err_ebox_h = nxm_ebox_q;
    assign adr_par_err_h  = par_q;

endmodule

// File: doc/mbox_core_arb.md
# mbox_core_arb

Memory-cycle arbiter and sequencer for the MBOX core-memory port. It shares one backplane memory port among three requesters: channel, cache writeback and EBOX. It issues the start and read/write request strobes and tracks ACKN and data-valid handshakes. On non-existent memory it synthesizes the missing data-valid strobes and records sticky per-requester error flags for APR reporting.

## Interface
Parameters:
- NXM_TIMEOUT, 32: cycles without ACKN, or between data words, before a non-existent-memory (NXM) event is declared.
- STARVE_LIMIT, 4: consecutive lost arbitrations before EBOX is promoted to top priority.

Ports:
- clk_mbx_h  in  1  MBOX clock; every flop uses the rising edge.
- mr_reset_h  in  1  asynchronous, active-high reset.
- chan_req_h, wb_req_h, ebox_req_h  in  1 each  request from each requester; held high until that requester's cyc_done_h.
- chan_wr_h, ebox_wr_h  in  1 each  1 = write, 0 = read. Writeback is always a write.
- chan_nwords_h, wb_nwords_h, ebox_nwords_h  in  2 each  word count; 0 encodes 4, otherwise 1–3.
- grant_chan_h, grant_wb_h, grant_ebox_h  out  1 each  one-hot grant, held from START through DONE.
- mem_start_h  out  1  one-cycle memory start pulse.
- mem_rd_rq_h, mem_wr_rq_h  out  1 each  request type, held from START through DONE.
- mem_ackn_h  in  1  memory acknowledge.
- mem_data_val_h  in  1  memory data-valid, one pulse per word.
- mem_adr_par_err_h  in  1  address-parity error; sampled together with ACKN.
- core_busy_h  out  1  high in every state except IDLE.
- data_val_h  out  1  data-valid to the granted requester; real or synthesized.
- cyc_done_h  out  1  one-cycle pulse marking the end of the cycle.
- nxm_any_h  out  1  high while in the NXM state.
- nxm_err_chan_h, nxm_err_ebox_h, adr_par_err_h  out  1 each  sticky error flags.
- err_clr_h  in  1  clears all sticky error flags.

All outputs reset to 0.

## Operation
States: IDLE, START, WAIT_ACK, WAIT_DATA, NXM, DONE.

- **IDLE**
  - Arbitrates when any request is high. Priority is channel > writeback > EBOX, except as modified by starvation promotion (see Configuration).
  - Latches the winner's grant, rd/wr and word count (WC, 1–4). Moves to START.
- **START**
  - mem_start_h = 1. The wait timer is cleared. Moves to WAIT_ACK.
  - ACKN arriving in START is honoured exactly as in WAIT_ACK.
- **WAIT_ACK**
  - On ACKN:
    - mem_adr_par_err_h = 1 sets adr_par_err_h.
    - A write moves to DONE.
    - A read moves to WAIT_DATA. If mem_data_val_h is high in the same cycle, that word counts.
  - If the timer reaches NXM_TIMEOUT, moves to NXM.
- **WAIT_DATA**
  - Each mem_data_val_h produces data_val_h in the same cycle (combinational pass-through), increments the received count and clears the timer.
  - count == WC moves to DONE. Timer expiry moves to NXM.
  - mem_data_val_h outside WAIT_DATA (and outside the ACKN cycle) is ignored and not passed through.
- **NXM**
  - Sets the sticky NXM flag: nxm_err_chan_h for the channel, nxm_err_ebox_h for EBOX. Writeback NXM sets nxm_err_ebox_h.
  - For reads, issues one registered data_val_h per cycle until count == WC. A write issues none.
  - Then moves to DONE.
- **DONE**
  - cyc_done_h = 1; grant and request type deassert next cycle. Returns to IDLE.
  - A fresh arbitration occurs in IDLE on the following cycle; there are no back-to-back grants without passing through IDLE.

Sticky flags:
- Set has priority over a simultaneous err_clr_h.
- Flags survive cycle completion; only err_clr_h or reset clears them.

Widths and boundaries:
- The timer is $clog2(NXM_TIMEOUT+1) bits and saturates.
- The word counter is 3 bits.
- A request dropped mid-cycle does not abort the cycle.
- Reset mid-cycle forces IDLE with all outputs 0 and no cyc_done_h. Sticky flags clear.

## Timing
- Request high in cycle 0 (IDLE):
  - Cycle 1: START; grant, mem_start_h, core_busy_h and rq high.
  - ACKN is earliest in cycle 1.
- Minimum write: ACKN in cycle 1 → DONE in cycle 2 → IDLE in cycle 3.
- Read: cyc_done_h follows the last data_val_h by exactly 1 cycle.
- NXM: declared NXM_TIMEOUT cycles after the last START, ACKN or data word.

## Configuration
- MBOX_ARB_STARVE_EN defined:
  - An EBOX lost-arbitration counter increments each IDLE arbitration in which EBOX requested and lost.
  - It clears when EBOX is granted.
  - At STARVE_LIMIT, EBOX wins the next arbitration regardless of the other requests.
- MBOX_ARB_STARVE_EN undefined: strict fixed priority; the counter logic is absent.

## Structure
- Shared package mbox_pkg holds:
  - the state enum (mbox_arb_state_t);
  - the requester index enum (CHAN, WB, EBOX);
  - the nwords-to-count decode function.
- One sub-module, mbox_arb_prio: combinational priority pick plus the starvation counter.
- The FSM, timer and error flags stay in mbox_core_arb.

## Test plan
- EBOX read, nwords = 0: ACKN in cycle 3, data-valid in cycles 4–7 → four data_val_h, cyc_done_h in cycle 8, core_busy_h cycles 1–8.
- Channel and EBOX requesting in the same cycle → grant_chan_h first; EBOX granted only after channel cyc_done_h plus IDLE.
- Channel read, nwords = 2, no ACKN, NXM_TIMEOUT = 32:
  - NXM at cycle 33; two synthesized data_val_h; cyc_done_h; nxm_err_chan_h = 1.
  - err_clr_h asserted together with a new NXM → flag stays 1.
- Writeback write with ACKN and mem_adr_par_err_h in cycle 1 → adr_par_err_h = 1, cyc_done_h in cycle 2, no data_val_h.
- MBOX_ARB_STARVE_EN defined, STARVE_LIMIT = 4: channel requests continuously and EBOX continuously → EBOX granted on the 5th arbitration. Without the macro, EBOX is never granted.
- mr_reset_h asserted during WAIT_DATA after 2 of 4 words → all outputs 0 next edge, no cyc_done_h, state IDLE.
